// File: rtl/sphn_pong_ctrl.sv
// Purpose : per-frame pong sequencer that owns the paddle, ball, score and lives (IDLE/SERVE/PLAY/OVER).
// Latency : the tick is registered at edge T, the paddle updates at T+2, and ball/score/lives/state update at T+4.
// Backpr. : none; a frame tick that arrives while an update is pending or running is dropped.
// Ports   : pix_clk/pix_rst (async, active-high); i_frame_tick (vblank pulse); i_move_up/i_move_down/i_start
//           (async buttons, synchronized here); o_paddle_y, o_ball_x, o_ball_y, o_score, o_lives, o_state, o_won,
//           o_busy (high while the outputs are mid-update and must not be sampled by the renderer).
module sphn_pong_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PADDLE_X     = 16,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SZ      = 8,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int LIVES        = 3
) (
  input  logic       pix_clk,
  input  logic       pix_rst,
  input  logic       i_frame_tick,
  input  logic       i_move_up,
  input  logic       i_move_down,
  input  logic       i_start,
  output logic [9:0] o_paddle_y,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [3:0] o_score,
  output logic [1:0] o_lives,
  output logic [1:0] o_state,
  output logic       o_won,
  output logic       o_busy
);

  localparam int PY_MAX    = V_ACTIVE - PADDLE_H;
  localparam int BX_MAX    = H_ACTIVE - BALL_SZ;
  localparam int BY_MAX    = V_ACTIVE - BALL_SZ;
  localparam int HIT_X     = PADDLE_X + PADDLE_W;
  localparam int BALL_X0   = (H_ACTIVE - BALL_SZ) / 2;
  localparam int BALL_Y0   = (V_ACTIVE - BALL_SZ) / 2;
  localparam int PADDLE_Y0 = (V_ACTIVE - PADDLE_H) / 2;
  localparam int CNT_W     = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic signed [11:0] BX_MAX_S = 12'(BX_MAX);
  localparam logic signed [11:0] BY_MAX_S = 12'(BY_MAX);
  localparam logic signed [11:0] HIT_X_S  = 12'(HIT_X);
  localparam logic signed [11:0] STEP_S   = 12'(BALL_STEP);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SERVE = 2'd1, ST_PLAY = 2'd2, ST_OVER = 2'd3} state_t;
  typedef enum logic [1:0] {PH_WAIT, PH_PADDLE, PH_BALL, PH_RESOLVE} phase_t;

  state_t             state;
  phase_t             phase;
  logic               tick_q;
  logic               busy;
  logic [1:0]         up_sync, down_sync, start_sync;
  logic [9:0]         paddle_y, ball_x, ball_y;
  logic               ball_dx_left, ball_dy_down;
  logic [3:0]         score;
  logic [1:0]         lives;
  logic               won;
  logic [CNT_W-1:0]   serve_cnt;
  // Candidate position computed in BALL; signed so that steps past 0 are visible.
  logic signed [11:0] nx, ny;

  logic up_s, down_s, start_s;
  assign up_s    = up_sync[1];
  assign down_s  = down_sync[1];
  assign start_s = start_sync[1];

  // Resolution of the candidate position against walls and paddle.
  logic [9:0] r_x, r_y;
  logic       r_dx_left, r_dy_down;
  logic       overlap, hit, miss;

  always_comb begin
    r_x       = ball_x;
    r_y       = ball_y;
    r_dx_left = ball_dx_left;
    r_dy_down = ball_dy_down;
    hit       = 1'b0;
    miss      = 1'b0;

    if (ny < 12'sd0) begin
      r_y       = '0;
      r_dy_down = 1'b1;
    end else if (ny > BY_MAX_S) begin
      r_y       = 10'(BY_MAX);
      r_dy_down = 1'b0;
    end else begin
      r_y = ny[9:0];
    end

    // Overlap uses the resolved y and the paddle position already moved this frame.
    overlap = (({1'b0, r_y} + 11'(BALL_SZ)) > {1'b0, paddle_y}) &&
              ({1'b0, r_y} < ({1'b0, paddle_y} + 11'(PADDLE_H)));

    if (nx > BX_MAX_S) begin
      r_x       = 10'(BX_MAX);
      r_dx_left = 1'b1;
    end else if (ball_dx_left && (ball_x >= 10'(HIT_X)) && (nx < HIT_X_S) && overlap) begin
      hit       = 1'b1;
      r_x       = 10'(HIT_X);
      r_dx_left = 1'b0;
    end else if (ball_dx_left && (nx < 12'sd0)) begin
      miss = 1'b1;
    end else begin
      r_x = nx[9:0];
    end
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      state        <= ST_IDLE;
      phase        <= PH_WAIT;
      tick_q       <= 1'b0;
      busy         <= 1'b0;
      up_sync      <= '0;
      down_sync    <= '0;
      start_sync   <= '0;
      paddle_y     <= 10'(PADDLE_Y0);
      ball_x       <= 10'(BALL_X0);
      ball_y       <= 10'(BALL_Y0);
      ball_dx_left <= 1'b1;
      ball_dy_down <= 1'b1;
      score        <= '0;
      lives        <= 2'(LIVES);
      won          <= 1'b0;
      serve_cnt    <= '0;
      nx           <= '0;
      ny           <= '0;
    end else begin
      up_sync    <= {up_sync[0], i_move_up};
      down_sync  <= {down_sync[0], i_move_down};
      start_sync <= {start_sync[0], i_start};

      case (phase)
        PH_WAIT: begin
          if (tick_q) begin
            tick_q <= 1'b0;
            busy   <= 1'b1;
            phase  <= PH_PADDLE;
          end else if (i_frame_tick) begin
            tick_q <= 1'b1;
          end
        end

        PH_PADDLE: begin
          if (state != ST_OVER) begin
            if (up_s && !down_s) begin
              if (paddle_y < 10'(PADDLE_STEP)) paddle_y <= '0;
              else                             paddle_y <= paddle_y - 10'(PADDLE_STEP);
            end else if (down_s && !up_s) begin
              if (({1'b0, paddle_y} + 11'(PADDLE_STEP)) > 11'(PY_MAX)) paddle_y <= 10'(PY_MAX);
              else                                                   paddle_y <= paddle_y + 10'(PADDLE_STEP);
            end
          end
          phase <= PH_BALL;
        end

        PH_BALL: begin
          if (state == ST_PLAY) begin
            nx <= ball_dx_left ? ($signed({2'b00, ball_x}) - STEP_S) : ($signed({2'b00, ball_x}) + STEP_S);
            ny <= ball_dy_down ? ($signed({2'b00, ball_y}) + STEP_S) : ($signed({2'b00, ball_y}) - STEP_S);
          end
          phase <= PH_RESOLVE;
        end

        PH_RESOLVE: begin
          phase <= PH_WAIT;
          busy  <= 1'b0;
          case (state)
            ST_IDLE: begin
              if (start_s) begin
                state     <= ST_SERVE;
                serve_cnt <= '0;
              end
            end

            ST_SERVE: begin
              if (serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                state     <= ST_PLAY;
                serve_cnt <= '0;
              end else begin
                serve_cnt <= serve_cnt + 1'b1;
              end
            end

            ST_PLAY: begin
              ball_x       <= r_x;
              ball_y       <= r_y;
              ball_dx_left <= r_dx_left;
              ball_dy_down <= r_dy_down;
              if (hit) begin
                if (score < 4'(WIN_SCORE)) score <= score + 4'd1;
                if (score == 4'(WIN_SCORE - 1)) begin
                  won   <= 1'b1;
                  state <= ST_OVER;
                end
              end else if (miss) begin
                ball_x       <= 10'(BALL_X0);
                ball_y       <= 10'(BALL_Y0);
                ball_dx_left <= 1'b1;
                ball_dy_down <= 1'b1;
                if (lives != 2'd0) lives <= lives - 2'd1;
                if (lives <= 2'd1) begin
                  state <= ST_OVER;
                end else begin
                  state     <= ST_SERVE;
                  serve_cnt <= '0;
                end
              end
            end

            ST_OVER: begin
              if (start_s) begin
                score        <= '0;
                lives        <= 2'(LIVES);
                won          <= 1'b0;
                ball_x       <= 10'(BALL_X0);
                ball_y       <= 10'(BALL_Y0);
                ball_dx_left <= 1'b1;
                ball_dy_down <= 1'b1;
                paddle_y     <= 10'(PADDLE_Y0);
                serve_cnt    <= '0;
                state        <= ST_SERVE;
              end
            end

            default: state <= ST_IDLE;
          endcase
        end

        default: phase <= PH_WAIT;
      endcase
    end
  end

  assign o_paddle_y = paddle_y;
  assign o_ball_x   = ball_x;
  assign o_ball_y   = ball_y;
  assign o_score    = score;
  assign o_lives    = lives;
  assign o_state    = state;
  assign o_won      = won;
  assign o_busy     = busy;

endmodule

// File: tb/tb_sphn_pong_ctrl.sv
// Purpose : self-checking bench for sphn_pong_ctrl using directed vectors and hand-derived trajectories.
// Latency : one frame tick every 7 pix_clk cycles, so each update completes well before the next tick.
// Backpr. : none; buttons change only between frames.
module tb_sphn_pong_ctrl;

  logic       pix_clk = 1'b0;
  logic       pix_rst;
  logic       i_frame_tick;
  logic       i_move_up;
  logic       i_move_down;
  logic       i_start;
  logic [9:0] o_paddle_y, o_ball_x, o_ball_y;
  logic [3:0] o_score;
  logic [1:0] o_lives;
  logic [1:0] o_state;
  logic       o_won;
  logic       o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  sphn_pong_ctrl dut (
    .pix_clk      (pix_clk),
    .pix_rst      (pix_rst),
    .i_frame_tick (i_frame_tick),
    .i_move_up    (i_move_up),
    .i_move_down  (i_move_down),
    .i_start      (i_start),
    .o_paddle_y   (o_paddle_y),
    .o_ball_x     (o_ball_x),
    .o_ball_y     (o_ball_y),
    .o_score      (o_score),
    .o_lives      (o_lives),
    .o_state      (o_state),
    .o_won        (o_won),
    .o_busy       (o_busy)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct {
    int n;
    int x;
    int y;
    int score;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge pix_clk) i_frame_tick = 1'b1;
    @(negedge pix_clk) i_frame_tick = 1'b0;
    repeat (5) @(negedge pix_clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " paddle_y"}, int'(o_paddle_y), 208);
    chk({tag, " ball_x"}, int'(o_ball_x), 316);
    chk({tag, " ball_y"}, int'(o_ball_y), 236);
    chk({tag, " score"}, int'(o_score), 0);
    chk({tag, " lives"}, int'(o_lives), 3);
    chk({tag, " state"}, int'(o_state), 0);
    chk({tag, " won"}, int'(o_won), 0);
    chk({tag, " busy"}, int'(o_busy), 0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int   vi;
    int   busy_cnt;
    int   tgt;
    int   p;
    bit   ended;

    // Play-tick checkpoints of the first game (paddle held down until the first hit).
    vecs[0]  = '{1,   314, 238, 0};
    vecs[1]  = '{118,  80, 472, 0};
    vecs[2]  = '{119,  78, 472, 0};
    vecs[3]  = '{120,  76, 470, 0};
    vecs[4]  = '{146,  24, 418, 0};
    vecs[5]  = '{147,  24, 416, 1};
    vecs[6]  = '{148,  26, 414, 1};
    vecs[7]  = '{355, 440,   0, 1};
    vecs[8]  = '{356, 442,   0, 1};
    vecs[9]  = '{357, 444,   2, 1};
    vecs[10] = '{451, 632, 190, 1};
    vecs[11] = '{452, 632, 192, 1};
    vecs[12] = '{453, 630, 194, 1};

    pix_rst      = 1'b1;
    i_frame_tick = 1'b0;
    i_move_up    = 1'b0;
    i_move_down  = 1'b0;
    i_start      = 1'b0;
    repeat (3) @(negedge pix_clk);
    pix_rst = 1'b0;
    @(negedge pix_clk);
    chk_reset_vals("reset");

    // One idle tick: busy exactly three cycles, starting one cycle after the tick edge.
    @(negedge pix_clk) i_frame_tick = 1'b1;
    @(negedge pix_clk) i_frame_tick = 1'b0;
    chk("busy_at_T", int'(o_busy), 0);
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pix_clk);
      if (o_busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 3);
    chk("idle_tick paddle_y", int'(o_paddle_y), 208);
    chk("idle_tick ball_x", int'(o_ball_x), 316);
    chk("idle_tick state", int'(o_state), 0);

    // Hold up: first tick also checks that the paddle moves at the edge ending PADDLE.
    i_move_up = 1'b1;
    repeat (3) @(negedge pix_clk);
    @(negedge pix_clk) i_frame_tick = 1'b1;
    @(negedge pix_clk) i_frame_tick = 1'b0;
    @(negedge pix_clk);
    chk("paddle_before_T2", int'(o_paddle_y), 208);
    @(negedge pix_clk);
    chk("paddle_after_T2", int'(o_paddle_y), 204);
    repeat (3) @(negedge pix_clk);
    for (int k = 2; k <= 60; k++) begin
      do_tick();
      if (k == 51) chk("up_tick51 paddle_y", int'(o_paddle_y), 4);
      if (k == 52) chk("up_tick52 paddle_y", int'(o_paddle_y), 0);
    end
    chk("up_tick60 paddle_y", int'(o_paddle_y), 0);

    i_move_down = 1'b1;
    do_tick();
    do_tick();
    chk("both_held paddle_y", int'(o_paddle_y), 0);
    i_move_up = 1'b0;
    do_tick();
    chk("down_one paddle_y", int'(o_paddle_y), 4);

    // Start, serve countdown, then play.
    i_start = 1'b1;
    do_tick();
    chk("start state", int'(o_state), 1);
    i_start = 1'b0;
    for (int k = 1; k <= 59; k++) do_tick();
    chk("serve59 state", int'(o_state), 1);
    chk("serve59 ball_x", int'(o_ball_x), 316);
    do_tick();
    chk("serve60 state", int'(o_state), 2);
    chk("serve60 ball_y", int'(o_ball_y), 236);

    vi = 0;
    ended = 1'b0;
    for (int n = 1; n <= 6000; n++) begin
      if (n <= 147) begin
        i_move_up   = 1'b0;
        i_move_down = 1'b1;
      end else begin
        tgt = int'(o_ball_y) - 28;
        if (tgt < 0) tgt = 0;
        if (tgt > 416) tgt = 416;
        p = int'(o_paddle_y);
        i_move_down = (p + 4 <= tgt);
        i_move_up   = (p - 4 >= tgt);
      end
      do_tick();
      if (vi < 13 && vecs[vi].n == n) begin
        chk($sformatf("play%0d ball_x", n), int'(o_ball_x), vecs[vi].x);
        chk($sformatf("play%0d ball_y", n), int'(o_ball_y), vecs[vi].y);
        chk($sformatf("play%0d score", n), int'(o_score), vecs[vi].score);
        vi++;
      end
      if (o_state == 2'd3) begin
        ended = 1'b1;
        break;
      end
    end
    chk("vectors_visited", vi, 13);
    chk("win_reached", int'(ended), 1);
    chk("win score", int'(o_score), 9);
    chk("win won", int'(o_won), 1);
    chk("win lives", int'(o_lives), 3);
    chk("win state", int'(o_state), 3);

    // Reset asserted in the middle of an update sequence.
    i_move_up   = 1'b1;
    i_move_down = 1'b0;
    @(negedge pix_clk) i_frame_tick = 1'b1;
    @(negedge pix_clk) i_frame_tick = 1'b0;
    @(negedge pix_clk);
    chk("midseq busy", int'(o_busy), 1);
    pix_rst = 1'b1;
    @(negedge pix_clk);
    chk_reset_vals("midseq_rst");
    pix_rst = 1'b0;
    repeat (3) @(negedge pix_clk);

    // Three misses with the paddle parked at the top.
    i_start = 1'b1;
    do_tick();
    chk("miss_start state", int'(o_state), 1);
    i_start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      for (int k = 1; k <= 60; k++) do_tick();
      chk($sformatf("miss%0d play state", g), int'(o_state), 2);
      for (int k = 1; k <= 158; k++) do_tick();
      chk($sformatf("miss%0d pre ball_x", g), int'(o_ball_x), 0);
      chk($sformatf("miss%0d pre ball_y", g), int'(o_ball_y), 394);
      chk($sformatf("miss%0d pre lives", g), int'(o_lives), 3 - g);
      do_tick();
      chk($sformatf("miss%0d paddle_y", g), int'(o_paddle_y), 0);
      chk($sformatf("miss%0d lives", g), int'(o_lives), 2 - g);
      chk($sformatf("miss%0d ball_x", g), int'(o_ball_x), 316);
      chk($sformatf("miss%0d ball_y", g), int'(o_ball_y), 236);
      chk($sformatf("miss%0d state", g), int'(o_state), (g < 2) ? 1 : 3);
    end
    chk("lost won", int'(o_won), 0);
    chk("lost score", int'(o_score), 0);

    // OVER freezes the paddle; start restarts the game.
    i_move_up   = 1'b0;
    i_move_down = 1'b1;
    do_tick();
    chk("over_frozen paddle_y", int'(o_paddle_y), 0);
    chk("over_frozen state", int'(o_state), 3);
    i_move_down = 1'b0;
    i_start     = 1'b1;
    do_tick();
    i_start = 1'b0;
    chk("restart state", int'(o_state), 1);
    chk("restart lives", int'(o_lives), 3);
    chk("restart paddle_y", int'(o_paddle_y), 208);
    chk("restart ball_x", int'(o_ball_x), 316);
    chk("restart won", int'(o_won), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
